// File: rtl/secuenciador_compuertas_if.sv
// Operand/handshake bundle between the gate self-test sequencer and the gates under test.
// SECUENCIADOR_FIRST_FAIL_EN adds the first-failing-vector capture signals.
interface secuenciador_compuertas_if;
    logic       start;
    logic       out_and;
    logic       out_or;
    logic       out_not;
    logic       A;
    logic       B;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_count;
`ifdef SECUENCIADOR_FIRST_FAIL_EN
    logic       first_fail_valid;
    logic [1:0] first_fail_vec;

    modport master (
        input  start, out_and, out_or, out_not,
        output A, B, busy, done, pass, err_count, first_fail_valid, first_fail_vec
    );
    modport slave (
        output start, out_and, out_or, out_not,
        input  A, B, busy, done, pass, err_count, first_fail_valid, first_fail_vec
    );
`else
    modport master (
        input  start, out_and, out_or, out_not,
        output A, B, busy, done, pass, err_count
    );
    modport slave (
        output start, out_and, out_or, out_not,
        input  A, B, busy, done, pass, err_count
    );
`endif
endinterface

// File: rtl/secuenciador_compuertas.sv
// Clocked self-test sequencer for the AND/OR/NOT gate library: sweeps {A,B}, checks, counts errors.
// Optional SECUENCIADOR_FIRST_FAIL_EN captures the first mismatching vector of a run.
module secuenciador_compuertas #(
    parameter int SETTLE_CYCLES = 1,
    parameter int NUM_PASSES    = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    secuenciador_compuertas_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

    localparam logic [2:0] SETTLE_LOAD = 3'(SETTLE_CYCLES);
    localparam logic [2:0] LAST_PASS   = 3'(NUM_PASSES - 1);
    localparam state_t     AFTER_LOAD  = (SETTLE_CYCLES > 0) ? S_SETTLE : S_CHECK;

    state_t     state_q, state_n;
    logic [1:0] vec_q, vec_n;
    logic [2:0] settle_q, settle_n;
    logic [2:0] pass_q, pass_n;
    logic       busy_q, busy_n;
    logic       done_q, done_n;
    logic [3:0] err_q, err_n;
    logic       mismatch;
`ifdef SECUENCIADOR_FIRST_FAIL_EN
    logic       ffv_q, ffv_n;
    logic [1:0] ffvec_q, ffvec_n;
`endif

    // One flag per vector, however many gates disagree
    assign mismatch = (bus.out_and != (vec_q[1] & vec_q[0])) ||
                      (bus.out_or  != (vec_q[1] | vec_q[0])) ||
                      (bus.out_not != ~vec_q[1]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            vec_q    <= '0;
            settle_q <= '0;
            pass_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= '0;
`ifdef SECUENCIADOR_FIRST_FAIL_EN
            ffv_q    <= 1'b0;
            ffvec_q  <= '0;
`endif
        end else begin
            state_q  <= state_n;
            vec_q    <= vec_n;
            settle_q <= settle_n;
            pass_q   <= pass_n;
            busy_q   <= busy_n;
            done_q   <= done_n;
            err_q    <= err_n;
`ifdef SECUENCIADOR_FIRST_FAIL_EN
            ffv_q    <= ffv_n;
            ffvec_q  <= ffvec_n;
`endif
        end
    end

    always_comb begin
        state_n  = state_q;
        vec_n    = vec_q;
        settle_n = settle_q;
        pass_n   = pass_q;
        busy_n   = busy_q;
        done_n   = done_q;
        err_n    = err_q;
`ifdef SECUENCIADOR_FIRST_FAIL_EN
        ffv_n    = ffv_q;
        ffvec_n  = ffvec_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    vec_n    = '0;
                    err_n    = '0;
                    pass_n   = '0;
                    busy_n   = 1'b1;
                    done_n   = 1'b0;
                    settle_n = SETTLE_LOAD;
`ifdef SECUENCIADOR_FIRST_FAIL_EN
                    ffv_n    = 1'b0;
                    ffvec_n  = '0;
`endif
                    state_n  = AFTER_LOAD;
                end
            end
            S_SETTLE: begin
                settle_n = settle_q - 3'd1;
                if (settle_q == 3'd1) state_n = S_CHECK;
            end
            S_CHECK: begin
                if (mismatch && (err_q != 4'hF)) err_n = err_q + 4'd1;
`ifdef SECUENCIADOR_FIRST_FAIL_EN
                if (mismatch && !ffv_q) begin
                    ffv_n   = 1'b1;
                    ffvec_n = vec_q;
                end
`endif
                settle_n = SETTLE_LOAD;
                if (vec_q != 2'b11) begin
                    vec_n   = vec_q + 2'd1;
                    state_n = AFTER_LOAD;
                end else if (pass_q != LAST_PASS) begin
                    pass_n  = pass_q + 3'd1;
                    vec_n   = '0;
                    state_n = AFTER_LOAD;
                end else begin
                    vec_n   = '0;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    state_n = S_DONE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign bus.A         = vec_q[1];
    assign bus.B         = vec_q[0];
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err_count = err_q;
    assign bus.pass      = done_q && (err_q == 4'd0);
`ifdef SECUENCIADOR_FIRST_FAIL_EN
    assign bus.first_fail_valid = ffv_q;
    assign bus.first_fail_vec   = ffvec_q;
`endif
endmodule

// File: tb/tb_secuenciador_compuertas.sv
// Directed bench for secuenciador_compuertas: ideal and faulty gate models, restart, reset.
// Covers the SECUENCIADOR_FIRST_FAIL_EN outputs when that macro is defined.
module tb_secuenciador_compuertas;
    logic clk;
    logic reset;
    logic f_and0;
    logic f_not1;
    int   tests;
    int   errors;

    secuenciador_compuertas_if bus1 ();
    secuenciador_compuertas_if bus8 ();

    secuenciador_compuertas dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    secuenciador_compuertas #(
        .SETTLE_CYCLES (0),
        .NUM_PASSES    (8)
    ) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8)
    );

    assign bus1.out_and = f_and0 ? 1'b0 : (bus1.A & bus1.B);
    assign bus1.out_or  = bus1.A | bus1.B;
    assign bus1.out_not = f_not1 ? 1'b1 : ~bus1.A;

    assign bus8.out_and = ~(bus8.A & bus8.B);
    assign bus8.out_or  = ~(bus8.A | bus8.B);
    assign bus8.out_not = bus8.A;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start1();
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
    endtask

    initial begin
        tests  = 0;
        errors = 0;
        reset  = 1'b1;
        f_and0 = 1'b0;
        f_not1 = 1'b0;
        bus1.start = 1'b0;
        bus8.start = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ab",   {bus1.A, bus1.B}, 8'h0);
        check("rst_busy", bus1.busy, 1'b0);
        check("rst_done", bus1.done, 1'b0);
        check("rst_pass", bus1.pass, 1'b0);
        check("rst_err",  bus1.err_count, 4'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_busy", bus1.busy, 1'b0);

        // Ideal gates, defaults: each vector held two cycles, done at start+8
        pulse_start1();
        for (int k = 0; k < 8; k++) begin
            check("t1_ab",   {bus1.A, bus1.B}, 8'(k / 2));
            check("t1_busy", bus1.busy, 1'b1);
            check("t1_done", bus1.done, 1'b0);
            @(negedge clk);
        end
        check("t1_done8", bus1.done, 1'b1);
        check("t1_busy8", bus1.busy, 1'b0);
        check("t1_pass",  bus1.pass, 1'b1);
        check("t1_err",   bus1.err_count, 4'd0);
        check("t1_ab8",   {bus1.A, bus1.B}, 8'h0);

        // AND stuck at 0: only vector 11 fails
        f_and0 = 1'b1;
        pulse_start1();
        repeat (8) @(negedge clk);
        check("and0_done", bus1.done, 1'b1);
        check("and0_err",  bus1.err_count, 4'd1);
        check("and0_pass", bus1.pass, 1'b0);
`ifdef SECUENCIADOR_FIRST_FAIL_EN
        check("and0_ffv",   bus1.first_fail_valid, 1'b1);
        check("and0_ffvec", bus1.first_fail_vec, 2'b11);
`endif

        // Restart while done: clears err_count and begins a new sweep
        f_and0 = 1'b0;
        pulse_start1();
        check("rs_done", bus1.done, 1'b0);
        check("rs_busy", bus1.busy, 1'b1);
        check("rs_err",  bus1.err_count, 4'd0);
        check("rs_ab",   {bus1.A, bus1.B}, 8'h0);
`ifdef SECUENCIADOR_FIRST_FAIL_EN
        check("rs_ffv",  bus1.first_fail_valid, 1'b0);
`endif
        repeat (8) @(negedge clk);
        check("rs_done8", bus1.done, 1'b1);
        check("rs_pass8", bus1.pass, 1'b1);

        // NOT stuck at 1: vectors 10 and 11 fail
        f_not1 = 1'b1;
        pulse_start1();
        repeat (8) @(negedge clk);
        check("not1_err",  bus1.err_count, 4'd2);
        check("not1_pass", bus1.pass, 1'b0);
`ifdef SECUENCIADOR_FIRST_FAIL_EN
        check("not1_ffv",   bus1.first_fail_valid, 1'b1);
        check("not1_ffvec", bus1.first_fail_vec, 2'b10);
`endif
        f_not1 = 1'b0;

        // start during a sweep is ignored
        pulse_start1();
        for (int k = 0; k <= 8; k++) begin
            if (k == 4) check("ign_ab4", {bus1.A, bus1.B}, 8'h2);
            if (k == 7) check("ign_done7", bus1.done, 1'b0);
            if (k == 8) begin
                check("ign_done8", bus1.done, 1'b1);
                check("ign_pass8", bus1.pass, 1'b1);
            end
            if (k == 2) bus1.start = 1'b1;
            if (k == 3) bus1.start = 1'b0;
            if (k < 8) @(negedge clk);
        end

        // 8 passes, no settle, every gate inverted: saturation and done at start+32
        bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (14) @(negedge clk);
        check("p8_err14", bus8.err_count, 4'd14);
        repeat (2) @(negedge clk);
        check("p8_err16", bus8.err_count, 4'd15);
        repeat (15) @(negedge clk);
        check("p8_done31", bus8.done, 1'b0);
        check("p8_busy31", bus8.busy, 1'b1);
        @(negedge clk);
        check("p8_done32", bus8.done, 1'b1);
        check("p8_err32",  bus8.err_count, 4'd15);
        check("p8_pass",   bus8.pass, 1'b0);
`ifdef SECUENCIADOR_FIRST_FAIL_EN
        check("p8_ffvec",  bus8.first_fail_vec, 2'b00);
`endif

        // Asynchronous reset mid-sweep at vector 10
        pulse_start1();
        repeat (4) @(negedge clk);
        check("ar_ab_pre", {bus1.A, bus1.B}, 8'h2);
        reset = 1'b1;
        #1;
        check("ar_ab",   {bus1.A, bus1.B}, 8'h0);
        check("ar_busy", bus1.busy, 1'b0);
        check("ar_done", bus1.done, 1'b0);
        check("ar_err",  bus1.err_count, 4'd0);
        check("ar_p8done", bus8.done, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("ar_idle_busy", bus1.busy, 1'b0);
        check("ar_idle_done", bus1.done, 1'b0);
        check("ar_idle_ab",   {bus1.A, bus1.B}, 8'h0);
        pulse_start1();
        check("ar_go_busy", bus1.busy, 1'b1);
        repeat (2) @(negedge clk);
        check("ar_go_ab2", {bus1.A, bus1.B}, 8'h1);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule

// File: doc/secuenciador_compuertas.md
# secuenciador_compuertas

Synthesizable self-test controller for the gate component library (AND, OR, NOT). It replaces the free-running stimulus of the bench with a clocked sequence that works in hardware:
- drives operands `A`/`B` through all four input combinations;
- waits a programmable settle time, then samples the three gate outputs against expected values;
- counts mismatching vectors and reports pass/fail.

It sits between the gate-library instances and whatever top level or bench issues `start`.

## Interface
- `SETTLE_CYCLES`, default 1: extra cycles each vector is held before its outputs are compared. Legal range 0–7.
- `NUM_PASSES`, default 1: number of full 4-vector sweeps per run. Legal range 1–8.

- `clk`  input  1  single clock, rising-edge.
- `reset`  input  1  asynchronous, active-high reset.
- `start`  input  1  run request; sampled only in IDLE and DONE.
- `out_and`  input  1  AND gate output under test (expected `A & B`).
- `out_or`  input  1  OR gate output under test (expected `A | B`).
- `out_not`  input  1  NOT gate output under test, fed by `A` (expected `~A`).
- `A`  output  1  operand A, registered.
- `B`  output  1  operand B, registered.
- `busy`  output  1  sweep in progress.
- `done`  output  1  run finished; level, held until the next run or reset.
- `pass`  output  1  `done && err_count == 0`.
- `err_count`  output  4  mismatching vectors, saturating at 15.

## Operation
- Vector order within a sweep: `{A,B}` = 00, 01, 10, 11, driven from a 2-bit vector counter.
- Pass counter: 3 bits, counts completed sweeps.
- IDLE: all outputs at reset values.
  - `start=1` → load vector 00 onto `A`,`B`; clear `err_count`; `busy<=1`; `done<=0`; load settle counter with `SETTLE_CYCLES`.
  - Next state is SETTLE if `SETTLE_CYCLES>0`, else CHECK.
- SETTLE: decrement the settle counter each cycle; go to CHECK when it reaches 0. `A`/`B` are held stable.
- CHECK (1 cycle): compare all three outputs against the expected values for the current `A`,`B`.
  - Any mismatch → `err_count` +1, saturating at 15. One increment per vector, regardless of how many gates disagree.
  - If vectors remain, apply the next vector and return to SETTLE or CHECK as above.
  - After vector 11, the pass counter advances. If `NUM_PASSES` are not yet done, wrap to 00 and continue.
  - Otherwise go to DONE: `busy<=0`, `done<=1`, `A`,`B` <= 00.
- DONE: outputs held.
  - `start=1` restarts exactly as from IDLE, same cycle behaviour.
  - `pass` is combinational from `done` and `err_count`.
- `start` while `busy=1` is ignored: no restart, no effect on the counters.
- `reset` asserted at any time, including mid-sweep → immediate return to IDLE. All outputs and internal counters reset asynchronously.
- Reset values: `A=0`, `B=0`, `busy=0`, `done=0`, `pass=0`, `err_count=0`; all `_EN` outputs 0.

## Timing
- Each vector is held for `SETTLE_CYCLES+1` cycles.
- Comparison happens on the rising edge that ends the vector's last cycle. The next vector is applied on that same edge.
- If `start` is seen at edge t0, `done` rises at edge t0 + 4·(`SETTLE_CYCLES`+1)·`NUM_PASSES`. With defaults, `done` rises 8 cycles after the start edge.
- `busy` is high from edge t0 to the edge where `done` rises. `busy` and `done` are never both 1.
- Gate outputs must be valid within `SETTLE_CYCLES`+1 cycles of an operand change. `SETTLE_CYCLES=0` is valid only for purely combinational gates.

## Configuration
- `SECUENCIADOR_FIRST_FAIL_EN` defined:
  - Adds output `first_fail_valid` (1 bit).
  - Adds output `first_fail_vec` (2 bits).
  - On the first mismatching CHECK of a run, these capture `{A,B}` and set valid. Later mismatches do not overwrite them.
  - Both are cleared on reset and on each accepted `start`.
- Macro undefined: neither port nor the capture logic exists. All other behaviour is identical.

## Test plan
- Ideal gate models, defaults, 1-cycle `start` pulse:
  - `A`,`B` step 00→01→10→11, two cycles each.
  - `done`=1 at start+8; `pass`=1; `err_count`=0.
- `out_and` stuck at 0:
  - `err_count`=1 (vector 11 only); `pass`=0.
  - With the macro: `first_fail_vec`=11, `first_fail_valid`=1.
- `out_not` stuck at 1:
  - `err_count`=2 (vectors 10, 11).
  - With the macro: `first_fail_vec`=10.
- `NUM_PASSES`=8, `SETTLE_CYCLES`=0, all outputs inverted:
  - 32 mismatches; `err_count` saturates at 15.
  - `done` at start+32.
- `start` pulsed at cycle 3 of a run: ignored, `done` still at start+8.
  - `start` while `done`=1: `done` drops next edge, `err_count` clears, a new sweep begins.
- `reset` asserted mid-sweep at vector 10:
  - All outputs return to 0 without waiting for a clock edge.
  - After release, state stays IDLE until `start`.
